// File: rtl/flag_cond_unit.sv
// NZCV flag register and condition evaluation downstream of the ALU.
// Ports: clk, reset (async low), Cond, ALUFlags, FlagW, PCS, NextPC,
//   RegW, MemW in; CondEx, Flags, PCWrite, RegWrite, MemWrite out.
module flag_cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       CondEx,
  output logic [3:0] Flags,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic n, z, c, v;
  logic cond_q;

  assign {n, z, c, v} = Flags;

  // Evaluated against the stored flags only, so a flag write
  // in this cycle is qualified by the old-flag result.
  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = !z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = !c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = !n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = !v;
      4'b1000: CondEx = c & !z;
      4'b1001: CondEx = !c | z;
      4'b1010: CondEx = (n == v);
      4'b1011: CondEx = (n != v);
      4'b1100: CondEx = !z & (n == v);
      4'b1101: CondEx = z | (n != v);
      4'b1110: CondEx = 1'b1;
      4'b1111: CondEx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags  <= 4'b0000;
      cond_q <= 1'b0;
    end else begin
      if (FlagW[1] & CondEx)
        Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] & CondEx)
        Flags[1:0] <= ALUFlags[1:0];
      cond_q <= CondEx;
    end
  end

  // Registered condition keeps strobes steady across FSM states;
  // fetch (NextPC) always advances the PC.
  assign RegWrite = RegW & cond_q;
  assign MemWrite = MemW & cond_q;
  assign PCWrite  = (PCS & cond_q) | NextPC;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed table-driven bench for flag_cond_unit.
// Vectors drive at negedge and check #1 after the next posedge.
module tb_flag_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW;
  logic       CondEx;
  logic [3:0] Flags;
  logic       PCWrite, RegWrite, MemWrite;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  flag_cond_unit dut (
    .clk(clk),
    .reset(reset),
    .Cond(Cond),
    .ALUFlags(ALUFlags),
    .FlagW(FlagW),
    .PCS(PCS),
    .NextPC(NextPC),
    .RegW(RegW),
    .MemW(MemW),
    .CondEx(CondEx),
    .Flags(Flags),
    .PCWrite(PCWrite),
    .RegWrite(RegWrite),
    .MemWrite(MemWrite)
  );

  typedef struct {
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       pcs;
    logic       npc;
    logic       rw;
    logic       mw;
    logic [3:0] ef;
    logic       ecx;
    logic       epc;
    logic       erw;
    logic       emw;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input int i);
    vec_t t;
    t = tv[i];
    @(negedge clk);
    Cond = t.cond; ALUFlags = t.alu; FlagW = t.fw;
    PCS = t.pcs; NextPC = t.npc; RegW = t.rw; MemW = t.mw;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d Flags", i), Flags, t.ef);
    chk($sformatf("v%0d CondEx", i), {3'b0, CondEx}, {3'b0, t.ecx});
    chk($sformatf("v%0d PCWrite", i), {3'b0, PCWrite}, {3'b0, t.epc});
    chk($sformatf("v%0d RegWrite", i), {3'b0, RegWrite}, {3'b0, t.erw});
    chk($sformatf("v%0d MemWrite", i), {3'b0, MemWrite}, {3'b0, t.emw});
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(i);
  endtask

  task automatic quiet();
    FlagW = 2'b00; PCS = 0; NextPC = 0; RegW = 0; MemW = 0;
  endtask

  task automatic cchk(input string name, input logic [3:0] c,
                      input logic e);
    Cond = c;
    #1;
    chk(name, {3'b0, CondEx}, {3'b0, e});
  endtask

  initial begin
    //         cond     alu      fw    pcs npc rw mw  ef       cx pc rw mw
    tv.push_back('{4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 4'b0100, 1, 0, 0, 0});
    tv.push_back('{4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0, 4'b0100, 1, 0, 1, 0});
    tv.push_back('{4'b0001, 4'b0000, 2'b00, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 0});
    tv.push_back('{4'b1110, 4'b0011, 2'b11, 0, 0, 0, 0, 4'b0011, 1, 0, 0, 0});
    tv.push_back('{4'b1110, 4'b1000, 2'b10, 0, 0, 0, 0, 4'b1011, 1, 0, 0, 0});
    tv.push_back('{4'b1110, 4'b0100, 2'b01, 0, 0, 0, 0, 4'b1000, 1, 0, 0, 0});
    // 6
    tv.push_back('{4'b1110, 4'b0001, 2'b01, 0, 0, 0, 0, 4'b1001, 1, 0, 0, 0});
    // 7
    tv.push_back('{4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0});
    tv.push_back('{4'b0000, 4'b1111, 2'b11, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0});
    tv.push_back('{4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 4'b0000, 0, 1, 0, 0});
    tv.push_back('{4'b1111, 4'b0000, 2'b00, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0});
    tv.push_back('{4'b1110, 4'b0000, 2'b00, 1, 0, 0, 0, 4'b0000, 1, 1, 0, 0});
    tv.push_back('{4'b0001, 4'b0100, 2'b11, 0, 0, 1, 0, 4'b0100, 0, 0, 1, 0});
    tv.push_back('{4'b0001, 4'b0000, 2'b00, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 0});
    // 14
    tv.push_back('{4'b1110, 4'b0010, 2'b11, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 0});
    // 15
    tv.push_back('{4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0, 4'b0010, 1, 0, 1, 0});

    reset = 0; Cond = 4'b0001; ALUFlags = 4'b1111; FlagW = 2'b11;
    PCS = 1; NextPC = 0; RegW = 1; MemW = 1;
    #2;
    chk("rst RegWrite", {3'b0, RegWrite}, 4'd0);
    chk("rst MemWrite", {3'b0, MemWrite}, 4'd0);
    chk("rst PCWrite", {3'b0, PCWrite}, 4'd0);
    chk("rst Flags", Flags, 4'b0000);
    chk("rst CondEx NE", {3'b0, CondEx}, 4'd1);
    @(posedge clk);
    #1;
    chk("rst hold Flags", Flags, 4'b0000);
    chk("rst hold RegWrite", {3'b0, RegWrite}, 4'd0);
    cchk("rst CondEx EQ", 4'b0000, 1'b0);
    NextPC = 1;
    #1;
    chk("rst PCWrite=NextPC", {3'b0, PCWrite}, 4'd1);
    @(negedge clk);
    quiet();
    reset = 1;

    run_range(0, 5);
    quiet();
    cchk("1000 LT", 4'b1011, 1'b1);
    cchk("1000 GE", 4'b1010, 1'b0);
    cchk("1000 GT", 4'b1100, 1'b0);
    cchk("1000 LE", 4'b1101, 1'b1);
    cchk("1000 MI", 4'b0100, 1'b1);
    cchk("1000 PL", 4'b0101, 1'b0);
    cchk("1000 LS", 4'b1001, 1'b1);

    run_range(6, 6);
    quiet();
    cchk("1001 GE", 4'b1010, 1'b1);
    cchk("1001 LT", 4'b1011, 1'b0);
    cchk("1001 GT", 4'b1100, 1'b1);
    cchk("1001 LE", 4'b1101, 1'b0);
    cchk("1001 VS", 4'b0110, 1'b1);
    cchk("1001 VC", 4'b0111, 1'b0);

    run_range(7, 14);
    quiet();
    cchk("0010 HI", 4'b1000, 1'b1);
    cchk("0010 LS", 4'b1001, 1'b0);
    cchk("0010 CS", 4'b0010, 1'b1);
    cchk("0010 CC", 4'b0011, 1'b0);
    cchk("0010 NV", 4'b1111, 1'b0);

    run_range(15, 15);
    #2;
    reset = 0;
    #1;
    chk("async RegWrite", {3'b0, RegWrite}, 4'd0);
    chk("async Flags", Flags, 4'b0000);
    chk("async PCWrite", {3'b0, PCWrite}, 4'd0);
    chk("async CondEx AL", {3'b0, CondEx}, 4'd1);
    @(negedge clk);
    reset = 1;
    Cond = 4'b1110;
    @(posedge clk);
    #1;
    chk("post-rst RegWrite", {3'b0, RegWrite}, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_cond_unit.md
# flag_cond_unit

Condition-evaluation and flag-holding stage that sits directly downstream of the ALU in the multi-cycle datapath. Registers the ALU's NZCV flags under control-unit write enables and evaluates the instruction's 4-bit condition field against the stored flags. Gates the control unit's architectural write strobes (PCWrite, RegWrite, MemWrite) with a registered condition result so they hold steady across multi-cycle states.

## Interface
Parameters: none.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Cond  input  4  instruction condition field, stable for the whole instruction
- ALUFlags  input  4  ALU flags {N,Z,C,V}; C=V=0 for logic/MUL/SMUL ops
- FlagW  input  2  flag write request: [1] updates N,Z; [0] updates C,V
- PCS  input  1  instruction writes PC (branch or Rd=R15)
- NextPC  input  1  unconditional PC+4 update (fetch state)
- RegW  input  1  register-file write request from control FSM
- MemW  input  1  memory write request from control FSM
- CondEx  output  1  combinational condition result from current Flags
- Flags  output  4  registered {N,Z,C,V}
- PCWrite  output  1  gated PC write enable
- RegWrite  output  1  gated register-file write enable
- MemWrite  output  1  gated memory write enable

## Operation
- State: Flags[3:0] register; CondExQ 1-bit register.
- CondEx is combinational from Cond and the *current* Flags register, never from ALUFlags:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 0 (treated as never)
- Flag update at the clock edge: Flags[3:2] <= ALUFlags[3:2] iff FlagW[1] & CondEx; Flags[1:0] <= ALUFlags[1:0] iff FlagW[0] & CondEx. A failed condition leaves the flags unchanged.
- CondExQ <= CondEx on every clock edge, with no enable.
- Outputs, all combinational from registered state and the control inputs:
  - RegWrite = RegW & CondExQ
  - MemWrite = MemW & CondExQ
  - PCWrite = (PCS & CondExQ) | NextPC
- NextPC is never gated; a fetch always advances the PC.

## Timing
- Reset (reset=0, asynchronous): Flags=4'b0000 and CondExQ=0. Therefore RegWrite=0 and MemWrite=0 while reset is low, and PCWrite=NextPC. CondEx reflects Cond with zero flags, e.g. EQ=0, NE=1, AL=1.
- Deassertion takes effect at the first rising edge after reset goes high; no extra wait states.
- Flag latency: flags written at edge k are visible on Flags and used by CondEx from cycle k+1.
- Simultaneous flag write and condition evaluation in the same cycle: CondEx uses the old flags, and the write is qualified by that old-flag CondEx.
- CondExQ lags CondEx by exactly one cycle. The control FSM asserts RegW/MemW/PCS no earlier than one cycle after Cond is stable (decode state), so the gating sees the settled value.
- Partial write: FlagW=2'b10 preserves the stored C,V while updating N,Z. FlagW=2'b01 is the converse.
- Reset asserted mid-instruction clears the flags and CondExQ immediately, with no clock required. Pending RegWrite/MemWrite drop in the same cycle.

## Test plan
- Reset: hold reset=0 with RegW=MemW=PCS=1, NextPC=0 -> RegWrite=MemWrite=PCWrite=0 and Flags=0000. Cond=0001 (NE) -> CondEx=1.
- EQ gating:
  - Cond=1110, FlagW=11, ALUFlags=0100, one edge -> Flags=0100.
  - Then Cond=0000, RegW=1; after one more edge -> RegWrite=1.
  - Cond=0001 -> RegWrite=0 one cycle later.
- Partial write: Flags=0011, then FlagW=10 with ALUFlags=1000 under AL -> Flags=1011.
- Failed condition blocks flags: Flags=0000, Cond=0000 (EQ false), FlagW=11, ALUFlags=1111 -> Flags stay 0000. MemW=1 -> MemWrite=0.
- Signed compares:
  - Flags=1000 (N=1, V=0) -> LT=1, GE=0, GT=0, LE=1.
  - Flags=1001 -> GE=1, LT=0.
- PC and reset overrides:
  - NextPC=1 with CondExQ=0 -> PCWrite=1.
  - PCS=1, Cond=1111 -> PCWrite=0.
  - Assert reset between clock edges during RegWrite=1 -> RegWrite falls without waiting for a clock edge.
